// File: rtl/avalon_led_pio_pkg.sv
// Shared register map for the Avalon-MM LED PIO with set/clear and blink support.
package avalon_led_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MODE     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/led_blink_timer.sv
// Free-running half-period timer; phase flips each time the counter reaches period.
module led_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PERIOD_W-1:0] count_q;
    logic                phase_q;

    // A restart wins over a terminal-count toggle on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else if (restart) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else if (count_q == period) begin
            count_q <= '0;
            phase_q <= ~phase_q;
        end else begin
            count_q <= count_q + PERIOD_W'(1);
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/avalon_led_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear and per-bit blink for board LEDs.
module avalon_led_pio_blink
    import avalon_led_pio_pkg::*;
#(
    parameter int                  WIDTH        = 8,
    parameter logic [WIDTH-1:0]    RESET_VALUE  = '0,
    parameter int                  PERIOD_W     = 24,
    parameter logic [PERIOD_W-1:0] RESET_PERIOD = PERIOD_W'(12499999)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port,
    output logic              blink_phase
);

    logic                we;
    logic                restart;
    logic                phase;
    logic [WIDTH-1:0]    wd_bits;

    logic [WIDTH-1:0]    data_q,   data_d;
    logic [WIDTH-1:0]    mode_q,   mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [WIDTH-1:0]    out_q,    out_d;

    logic                unused_writedata;

    assign we               = chipselect & ~write_n;
    assign wd_bits          = writedata[WIDTH-1:0];
    assign restart          = we && (address == ADDR_PERIOD);
    assign unused_writedata = &{1'b0, writedata};

    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        period_d = period_q;
        if (we) begin
            case (address)
                ADDR_DATA:     data_d   = wd_bits;
                ADDR_MODE:     mode_d   = wd_bits;
                ADDR_PERIOD:   period_d = writedata[PERIOD_W-1:0];
                ADDR_OUTSET:   data_d   = data_q | wd_bits;
                ADDR_OUTCLEAR: data_d   = data_q & ~wd_bits;
                default:       ;
            endcase
        end
    end

    // Blinking channels are gated by the phase; static channels pass DATA through.
    assign out_d = data_q & (~mode_q | {WIDTH{phase}});

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= RESET_VALUE;
            mode_q   <= '0;
            period_q <= RESET_PERIOD;
            out_q    <= RESET_VALUE;
        end else begin
            data_q   <= data_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            out_q    <= out_d;
        end
    end

    led_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .period  (period_q),
        .restart (restart),
        .phase   (phase)
    );

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]    = data_q;
            ADDR_MODE:   readdata[WIDTH-1:0]    = mode_q;
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
            ADDR_STATUS: readdata[0]            = phase;
            default:     readdata               = '0;
        endcase
    end

    assign out_port    = out_q;
    assign blink_phase = phase;

endmodule

// File: tb/tb_avalon_led_pio_blink.sv
// Directed bench for avalon_led_pio_blink: register map, set/clear, blink timing, reset.
module tb_avalon_led_pio_blink;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        blink_phase;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    avalon_led_pio_blink #(
        .WIDTH        (8),
        .RESET_VALUE  (8'hA5),
        .PERIOD_W     (24),
        .RESET_PERIOD (24'd12499999)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .out_port    (out_port),
        .blink_phase (blink_phase)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drives one write cycle; returns 1 time unit after the capturing edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] blink_phase_exp;
    logic [15:0] blink_out_exp;

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Reset state
        check("rst_out", {24'd0, out_port}, 32'h0000_00A5);
        check("rst_phase", {31'd0, blink_phase}, 32'd0);
        rd("rst_data", 3'd0, 32'h0000_00A5);
        rd("rst_mode", 3'd1, 32'h0000_0000);
        rd("rst_status", 3'd3, 32'h0000_0000);
        rd("rst_period", 3'd2, 32'h00BE_BC1F);

        // Full write, set, clear; out_port lags the register by one cycle
        wr(3'd0, 32'hFFFF_FF0F);
        check("data_out_lag", {24'd0, out_port}, 32'h0000_00A5);
        rd("data_rd", 3'd0, 32'h0000_000F);
        step();
        check("data_out", {24'd0, out_port}, 32'h0000_000F);

        wr(3'd4, 32'h0000_00C0);
        rd("set_rd", 3'd0, 32'h0000_00CF);
        rd("set_rd0", 3'd4, 32'h0000_0000);
        step();
        check("set_out", {24'd0, out_port}, 32'h0000_00CF);

        wr(3'd5, 32'h0000_0003);
        rd("clr_rd", 3'd0, 32'h0000_00CC);
        rd("clr_rd0", 3'd5, 32'h0000_0000);
        step();
        check("clr_out", {24'd0, out_port}, 32'h0000_00CC);

        // Blink with PERIOD=3: phase holds 4 cycles per level
        wr(3'd1, 32'h0000_0001);
        wr(3'd0, 32'h0000_0001);
        wr(3'd2, 32'h0000_0003);
        blink_phase_exp = 16'b1111_0000_1111_0000;
        blink_out_exp   = 16'b1110_0001_1110_0000;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("blink_ph%0d", k), {31'd0, blink_phase}, {31'd0, blink_phase_exp[k]});
            check($sformatf("blink_out%0d", k), {24'd0, out_port}, {31'd0, blink_out_exp[k]});
            step();
        end
        rd("blink_status", 3'd3, {31'd0, blink_phase});

        // PERIOD=0 toggles each cycle; rewrite on a would-be toggle edge restarts at 0
        wr(3'd2, 32'h0000_0000);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("p0_ph%0d", k), {31'd0, blink_phase}, k[0] ? 32'd1 : 32'd0);
            if (k < 4) step();
        end
        wr(3'd2, 32'h0000_0005);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("p5_ph%0d", k), {31'd0, blink_phase}, (k == 6) ? 32'd1 : 32'd0);
            if (k < 6) step();
        end

        // Reserved offsets
        wr(3'd6, 32'hFFFF_FFFF);
        rd("rsv_data", 3'd0, 32'h0000_0001);
        rd("rsv_mode", 3'd1, 32'h0000_0001);
        rd("rsv_period", 3'd2, 32'h0000_0005);
        rd("rsv_rd6", 3'd6, 32'h0000_0000);
        rd("rsv_rd7", 3'd7, 32'h0000_0000);

        // Reset while blinking with phase=1 and a write pending
        wr(3'd1, 32'h0000_00FF);
        wr(3'd2, 32'h0000_0000);
        step();
        check("pre_rst_phase", {31'd0, blink_phase}, 32'd1);
        @(negedge clk);
        reset      = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0000_0033;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("mid_rst_out", {24'd0, out_port}, 32'h0000_00A5);
        check("mid_rst_phase", {31'd0, blink_phase}, 32'd0);
        rd("mid_rst_period", 3'd2, 32'h00BE_BC1F);
        rd("mid_rst_mode", 3'd1, 32'h0000_0000);
        rd("mid_rst_data", 3'd0, 32'h0000_00A5);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_out", {24'd0, out_port}, 32'h0000_00A5);
        check("post_rst_phase", {31'd0, blink_phase}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/avalon_led_pio_blink.md
Name: avalon_led_pio_blink

Overview:
- Parametrised successor to the single-register Avalon-MM output PIO used for the board LEDs.
- Adds the following over the plain PIO:
  - WIDTH-bit output port.
  - Atomic set/clear write registers.
  - Per-bit static/blink mode, driven by a shared programmable blink timer.
- Sits on the Nios II data master's Avalon-MM interconnect as a slave; out_port drives LEDR/LEDG pins directly.

Parameters:
- WIDTH, 8, number of output bits (1..32).
- RESET_VALUE, 0, value loaded into DATA at reset (WIDTH bits).
- PERIOD_W, 24, width of the blink half-period register and counter (1..32).
- RESET_PERIOD, 12499999, PERIOD value at reset (0.25 s half-period at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  3  word address of register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, zero-extended
- out_port  out  WIDTH  LED drive
- blink_phase  out  1  current blink phase, for debug/LA

Behaviour:
- Single clock domain: clk.
- Reset is synchronous and active-high (`reset`), sampled on the rising edge of clk.
- Write strobe: we = chipselect & ~write_n. All register updates take effect on the clk edge where we=1.
- Register map (word offsets):
  - 0 DATA, rw: full write of writedata[WIDTH-1:0].
  - 1 MODE, rw: bit i = 1 selects blink for channel i; 0 selects static.
  - 2 PERIOD, rw: writedata[PERIOD_W-1:0]. Phase toggles every PERIOD+1 clk cycles.
  - 3 STATUS, ro: bit0 = phase; bits 31:1 = 0.
  - 4 OUTSET, wo: DATA <= DATA | writedata[WIDTH-1:0]. Reads 0.
  - 5 OUTCLEAR, wo: DATA <= DATA & ~writedata[WIDTH-1:0]. Reads 0.
  - 6 and 7: reserved. Writes are ignored; reads return 0.
- Read path:
  - Read latency 0: readdata is combinational from address and registers, with no chipselect qualification needed.
  - Unused upper bits are always 0.
- Reset values:
  - DATA = RESET_VALUE, MODE = 0, PERIOD = RESET_PERIOD.
  - Counter = 0, phase = 0.
  - Therefore out_port = RESET_VALUE in the cycle after reset, and readdata reflects the reset registers.
- Blink timer:
  - Each cycle, if counter == PERIOD: counter <= 0 and phase <= ~phase. Otherwise counter <= counter + 1.
  - PERIOD = 0 gives phase toggling every cycle.
  - Counter is unsigned PERIOD_W bits. The compare is ==, so no wrap beyond PERIOD can occur.
- Write to PERIOD: counter <= 0 and phase <= 0 on the same edge. This restarts the timer deterministically and overrides any terminal-count toggle in that cycle.
- Output:
  - out_port = DATA & (~MODE | {WIDTH{phase}}), registered.
  - out_port updates one cycle after the DATA/MODE/phase change, so it is glitch-free to the pins.
  - blink_phase = phase register.
- Simultaneous events: only one register is written per cycle (single address). A timer toggle and a DATA/MODE write in the same cycle both take effect.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of any pending write.
- writedata bits above WIDTH or PERIOD_W are ignored.

Decomposition:
- Package avalon_led_pio_pkg holds:
  - Register offsets: ADDR_DATA=0, ADDR_MODE=1, ADDR_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5.
  - ADDR_W=3.
- One sub-module, led_blink_timer:
  - Parameter: PERIOD_W.
  - Inputs: clk, reset, period, restart.
  - Output: phase.
  - Contains the counter and phase flop.
- The top level keeps the register file, read mux and output register.

Test Plan:
- Reset with RESET_VALUE=8'hA5: release reset -> out_port=8'hA5 and DATA read = 32'h000000A5, MODE read = 0, STATUS read = 0.
- Write DATA=8'h0F, then OUTSET=8'hC0, then OUTCLEAR=8'h03 -> DATA reads 8'h0F, then 8'hCF, then 8'hCC; out_port follows each one cycle later. OUTSET/OUTCLEAR read 0.
- PERIOD=3, MODE=8'h01, DATA=8'h01 -> out_port[0] is 0 for 4 cycles then 1 for 4 cycles, repeating; bits 7:1 stay 0.
- PERIOD=0 -> blink_phase toggles every cycle. Then rewrite PERIOD=5 mid-count -> phase=0 and counter=0 on that edge, with the next toggle exactly 6 cycles later.
- Write offset 6 with 32'hFFFFFFFF and read offsets 6 and 7 -> no register changes; both read 0.
- Assert reset for one cycle while MODE=8'hFF and phase=1 -> next cycle out_port=RESET_VALUE, PERIOD=RESET_PERIOD, phase=0.
